// File: rtl/clk_div_multi.sv
// clk_div_multi: N_CH independent clock-enable generators (tick + square wave) with runtime divisors.
// Latency: tick is registered, first tick is high after edge E(div) when en is sampled at E1; div_ack/div_err one cycle after div_wr.
// Backpressure: none. div_wr is always accepted or rejected in one cycle, with no stall.
//
// Ports: clk_ref/rst     clock, synchronous active-high reset
//        en, casc        per-channel run enable, cascade select (bit 0 unused)
//        div_wr/sel/val  divisor write strobe, target channel, value (must be >= 2)
//        div_ack/err     one-cycle write accepted / rejected pulses
//        tick, clk_sq    per-channel one-cycle tick and square wave
// Optional feature: define CLK_DIV_CASCADE_EN so that casc[k] selects tick[k-1] as the count source of channel k.
module clk_div_multi #(
    parameter int SEL_W   = 2,
    parameter int CNT_W   = 27,
    parameter int DIV_RST = 100
) (
    input  logic                clk_ref,
    input  logic                rst,
    input  logic [2**SEL_W-1:0] en,
    input  logic [2**SEL_W-1:0] casc,
    input  logic                div_wr,
    input  logic [SEL_W-1:0]    div_sel,
    input  logic [CNT_W-1:0]    div_val,
    output logic                div_ack,
    output logic                div_err,
    output logic [2**SEL_W-1:0] tick,
    output logic [2**SEL_W-1:0] clk_sq
);

    localparam int               N_CH     = 2**SEL_W;
    localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_RST);

    logic [CNT_W-1:0] r_cnt  [N_CH];
    logic [CNT_W-1:0] r_div  [N_CH];
    logic [CNT_W-1:0] r_pend [N_CH];
    logic [N_CH-1:0]  r_pv;
    logic [N_CH-1:0]  r_tick;
    logic [N_CH-1:0]  r_sq;
    logic             r_ack;
    logic             r_err;

    logic [N_CH-1:0]  w_src;
    logic [N_CH-1:0]  w_term;
    logic             w_wr_ok;
    logic             w_unused_casc;

    assign w_wr_ok = div_wr && (div_val >= CNT_W'(2));

    always_comb begin
        w_term = '0;
        for (int k = 0; k < N_CH; k++) begin
            w_term[k] = (r_cnt[k] == (r_div[k] - CNT_W'(1)));
        end
    end

`ifdef CLK_DIV_CASCADE_EN
    // Channel 0 always counts clk_ref; a cascaded channel counts the previous channel's registered tick.
    always_comb begin
        w_src = '1;
        for (int k = 1; k < N_CH; k++) begin
            if (casc[k]) begin
                w_src[k] = r_tick[k-1];
            end
        end
    end
    assign w_unused_casc = casc[0];
`else
    assign w_src         = '1;
    assign w_unused_casc = ^casc;
`endif

    always_ff @(posedge clk_ref) begin
        if (rst) begin
            for (int k = 0; k < N_CH; k++) begin
                r_cnt[k]  <= '0;
                r_div[k]  <= DIV_INIT;
                r_pend[k] <= '0;
            end
            r_pv   <= '0;
            r_tick <= '0;
            r_sq   <= '0;
            r_ack  <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_ack <= w_wr_ok;
            r_err <= div_wr && !w_wr_ok;
            for (int k = 0; k < N_CH; k++) begin
                if (!en[k]) begin
                    r_cnt[k]  <= '0;
                    r_tick[k] <= 1'b0;
                    r_sq[k]   <= 1'b0;
                    // An idle channel has no period to protect, so a pending divisor takes effect now.
                    if (r_pv[k]) begin
                        r_div[k] <= r_pend[k];
                        r_pv[k]  <= 1'b0;
                    end
                end else if (w_src[k]) begin
                    if (w_term[k]) begin
                        r_cnt[k]  <= '0;
                        r_tick[k] <= 1'b1;
                        // Counter restarts at 0, which is below div>>1 for any divisor >= 2.
                        r_sq[k]   <= 1'b1;
                        if (r_pv[k]) begin
                            r_div[k] <= r_pend[k];
                            r_pv[k]  <= 1'b0;
                        end
                    end else begin
                        r_cnt[k]  <= r_cnt[k] + CNT_W'(1);
                        r_tick[k] <= 1'b0;
                        r_sq[k]   <= (r_cnt[k] + CNT_W'(1)) < (r_div[k] >> 1);
                    end
                end else begin
                    r_tick[k] <= 1'b0;
                end
                // Placed after the apply logic so a write coincident with a terminal
                // event lands in pend and waits for the following terminal event.
                if (w_wr_ok && (div_sel == SEL_W'(k))) begin
                    r_pend[k] <= div_val;
                    r_pv[k]   <= 1'b1;
                end
            end
        end
    end

    assign div_ack = r_ack;
    assign div_err = r_err;
    assign tick    = r_tick;
    assign clk_sq  = r_sq;

endmodule
